// File: rtl/hwag_sync_ctrl.sv
// Crank-wheel synchronisation controller: arms the period counter, fills the
// period pipeline, hunts for the missing-tooth gap and tracks tooth index.
module hwag_sync_ctrl #(
  parameter int TCNT_WIDTH = 6,
  parameter int TCNT_TOP   = 57,
  parameter int TCNT_LOAD  = 3,   // must not exceed TCNT_TOP
  parameter int CONFIRM    = 2,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ena_i,
  input  logic                  edge_i,
  input  logic                  gap_i,
  input  logic                  gap_early_i,
  input  logic                  pcnt_ovf_i,
  output logic                  pcnt_run_o,
  output logic                  shift_ena_o,
  output logic [TCNT_WIDTH-1:0] tcnt_o,
  output logic                  sync_o,
  output logic                  rev_pulse_o,
  output logic                  lost_o,
  output logic [1:0]            last_err_o,
  output logic [ERR_WIDTH-1:0]  err_cnt_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_FILL    = 3'd2,
    S_SEARCH  = 3'd3,
    S_CONFIRM = 3'd4,
    S_SYNC    = 3'd5
  } state_e;

  localparam int CW = $clog2(CONFIRM + 1);
  localparam logic [CW-1:0]         CONF_LAST = CW'(CONFIRM - 1);
  localparam logic [TCNT_WIDTH-1:0] TOP       = TCNT_WIDTH'(TCNT_TOP);
  localparam logic [TCNT_WIDTH-1:0] LOAD      = TCNT_WIDTH'(TCNT_LOAD);

  state_e                state_q, state_d;
  logic [TCNT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [1:0]            fill_q, fill_d;
  logic [CW-1:0]         conf_q, conf_d;
  logic                  run_q, run_d;
  logic                  sync_q, sync_d;
  logic                  shift_q, shift_d;
  logic                  rev_q, rev_d;
  logic                  lost_q, lost_d;
  logic [1:0]            last_err_q, last_err_d;
  logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                  err_hit;
  logic [1:0]            err_code;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    fill_d     = fill_q;
    conf_d     = conf_q;
    run_d      = run_q;
    sync_d     = sync_q;
    shift_d    = 1'b0;
    rev_d      = 1'b0;
    lost_d     = 1'b0;
    last_err_d = last_err_q;
    err_cnt_d  = err_cnt_q;
    err_hit    = 1'b0;
    err_code   = 2'd0;

    if (!ena_i) begin
      state_d = S_IDLE;
      run_d   = 1'b0;
      sync_d  = 1'b0;
      tcnt_d  = '0;
    end else if (pcnt_ovf_i && (state_q inside {S_FILL, S_SEARCH, S_CONFIRM, S_SYNC})) begin
      err_hit  = 1'b1;
      err_code = 2'd1;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: if (edge_i) begin
          run_d   = 1'b1;
          fill_d  = '0;
          state_d = S_FILL;
        end
        // The arming edge counts as the first of three, so two FILL edges suffice.
        S_FILL: if (edge_i) begin
          shift_d = 1'b1;
          fill_d  = fill_q + 1'b1;
          if (fill_q == 2'd1) state_d = S_SEARCH;
        end
        S_SEARCH: if (edge_i) begin
          shift_d = 1'b1;
          if (gap_i) begin
            tcnt_d  = LOAD;
            conf_d  = '0;
            state_d = S_CONFIRM;
          end
        end
        S_CONFIRM, S_SYNC: if (edge_i) begin
          if (tcnt_q != TOP) begin
            if (gap_early_i) begin
              err_hit  = 1'b1;
              err_code = 2'd3;
            end else begin
              tcnt_d  = tcnt_q + 1'b1;
              shift_d = 1'b1;
            end
          end else if (gap_i) begin
            // Gap period is not shifted in: it would poison the comparators.
            tcnt_d = '0;
            if (state_q == S_SYNC) begin
              rev_d = 1'b1;
            end else begin
              conf_d = conf_q + 1'b1;
              if (conf_q == CONF_LAST) begin
                state_d = S_SYNC;
                sync_d  = 1'b1;
              end
            end
          end else begin
            err_hit  = 1'b1;
            err_code = 2'd2;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (err_hit) begin
      lost_d     = 1'b1;
      last_err_d = err_code;
      err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
      sync_d     = 1'b0;
      run_d      = 1'b0;
      tcnt_d     = '0;
      shift_d    = 1'b0;
      rev_d      = 1'b0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      tcnt_q     <= '0;
      fill_q     <= '0;
      conf_q     <= '0;
      run_q      <= 1'b0;
      sync_q     <= 1'b0;
      shift_q    <= 1'b0;
      rev_q      <= 1'b0;
      lost_q     <= 1'b0;
      last_err_q <= 2'd0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      fill_q     <= fill_d;
      conf_q     <= conf_d;
      run_q      <= run_d;
      sync_q     <= sync_d;
      shift_q    <= shift_d;
      rev_q      <= rev_d;
      lost_q     <= lost_d;
      last_err_q <= last_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign pcnt_run_o  = run_q;
  assign shift_ena_o = shift_q;
  assign tcnt_o      = tcnt_q;
  assign sync_o      = sync_q;
  assign rev_pulse_o = rev_q;
  assign lost_o      = lost_q;
  assign last_err_o  = last_err_q;
  assign err_cnt_o   = err_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Randomised scoreboard bench for hwag_sync_ctrl against a progress-count model.
module tb_hwag_sync_ctrl;

  localparam int TOP     = 57;
  localparam int LOAD    = 3;
  localparam int CONFIRM = 2;
  localparam int ERR_MAX = 255;

  typedef struct packed {
    logic       run;
    logic       shift;
    logic [5:0] tcnt;
    logic       sync;
    logic       rev;
    logic       lost;
    logic [1:0] lerr;
    logic [7:0] ecnt;
    logic [2:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0, edg = 1'b0, gap = 1'b0, gap_early = 1'b0, pcnt_ovf = 1'b0;
  logic       pcnt_run, shift_ena, sync, rev_pulse, lost;
  logic [5:0] tcnt;
  logic [1:0] last_err;
  logic [7:0] err_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  // Model: progress since arming, expressed as counts rather than states.
  bit m_active;
  int m_edges, m_gaps, m_tooth, m_errcnt, m_lasterr;
  bit m_found;

  always #5 clk = ~clk;

  hwag_sync_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .edge_i(edg), .gap_i(gap),
    .gap_early_i(gap_early), .pcnt_ovf_i(pcnt_ovf), .pcnt_run_o(pcnt_run),
    .shift_ena_o(shift_ena), .tcnt_o(tcnt), .sync_o(sync), .rev_pulse_o(rev_pulse),
    .lost_o(lost), .last_err_o(last_err), .err_cnt_o(err_cnt), .state_o(state)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int phase();
    if (!m_active)         return 0;
    if (m_edges == 0)      return 1;
    if (m_edges < 3)       return 2;
    if (!m_found)          return 3;
    if (m_gaps < CONFIRM)  return 4;
    return 5;
  endfunction

  function automatic void clear_progress();
    m_active = 0; m_edges = 0; m_found = 0; m_gaps = 0; m_tooth = 0;
  endfunction

  task automatic model(input bit en, input bit ed, input bit gp, input bit ge, input bit ov);
    int ph = phase();
    int code = 0;
    exp_t e;
    e = '0;
    if (!en) clear_progress();
    else if (ov && ph >= 2) code = 1;
    else if (ph == 0) m_active = 1;
    else if (ed) begin
      case (ph)
        1: m_edges = 1;
        2: begin e.shift = 1; m_edges++; end
        3: begin
          e.shift = 1;
          if (gp) begin m_found = 1; m_tooth = LOAD; m_gaps = 0; end
        end
        default: begin
          if (m_tooth != TOP) begin
            if (ge) code = 3;
            else begin m_tooth++; e.shift = 1; end
          end else if (gp) begin
            m_tooth = 0;
            if (ph == 5) e.rev = 1; else m_gaps++;
          end else code = 2;
        end
      endcase
    end
    if (code != 0) begin
      e.shift = 0; e.rev = 0; e.lost = 1;
      m_lasterr = code;
      if (m_errcnt < ERR_MAX) m_errcnt++;
      clear_progress();
    end
    e.run  = (phase() >= 2);
    e.sync = (phase() == 5);
    e.tcnt = 6'(m_tooth);
    e.st   = 3'(phase());
    e.lerr = 2'(m_lasterr);
    e.ecnt = 8'(m_errcnt);
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit en, input bit ed, input bit gp, input bit ge, input bit ov);
    @(negedge clk);
    ena = en; edg = ed; gap = gp; gap_early = ge; pcnt_ovf = ov;
    model(en, ed, gp, ge, ov);
  endtask

  // One edge preceded by 0..2 quiet cycles with random comparator levels.
  task automatic edge_cyc(input bit gp, input bit ge, input bit ov);
    repeat ($urandom_range(0, 2)) drive(1, 0, 1'($urandom), 1'($urandom), 0);
    drive(1, 1, gp, ge, ov);
  endtask

  task automatic nat_edge();
    int ph = phase();
    bit g;
    if (ph == 3)      g = 0;
    else if (ph >= 4) g = (m_tooth == TOP);
    else              g = 1'($urandom);
    edge_cyc(g, 0, 0);
  endtask

  task automatic sync_up();
    int guard = 0;
    if (phase() == 0) drive(1, 0, 0, 0, 1'($urandom));
    repeat (3) nat_edge();
    repeat ($urandom_range(0, 3)) edge_cyc(0, 0, 0);
    edge_cyc(1, 0, 0);
    while (phase() != 5 && guard < 300) begin nat_edge(); guard++; end
  endtask

  task automatic run_to_tooth(input int n);
    int guard = 0;
    while (m_tooth != n && guard < 100) begin nat_edge(); guard++; end
  endtask

  task automatic mid_reset();
    @(posedge clk); #3;
    ena = 0; edg = 0; gap = 0; gap_early = 0; pcnt_ovf = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_tcnt", tcnt, 0);
    chk("mid_rst_sync", sync, 0);
    chk("mid_rst_run", pcnt_run, 0);
    chk("mid_rst_lost", lost, 0);
    chk("mid_rst_errcnt", err_cnt, 0);
    clear_progress(); m_errcnt = 0; m_lasterr = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("state", state, e.st);
      chk("tcnt", tcnt, e.tcnt);
      chk("pcnt_run", pcnt_run, e.run);
      chk("shift_ena", shift_ena, e.shift);
      chk("sync", sync, e.sync);
      chk("rev_pulse", rev_pulse, e.rev);
      chk("lost", lost, e.lost);
      chk("last_err", last_err, e.lerr);
      chk("err_cnt", err_cnt, e.ecnt);
    end
  end

  initial begin
    clear_progress(); m_errcnt = 0; m_lasterr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_tcnt", tcnt, 0);
    chk("rst_run", pcnt_run, 0);
    chk("rst_shift", shift_ena, 0);
    chk("rst_sync", sync, 0);
    chk("rst_rev", rev_pulse, 0);
    chk("rst_lost", lost, 0);
    chk("rst_lasterr", last_err, 0);
    chk("rst_errcnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1;

    // Acquire sync, run a full revolution for rev_pulse, then a missing gap.
    sync_up();
    run_to_tooth(TOP);
    nat_edge();
    run_to_tooth(TOP);
    edge_cyc(0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Early gap inside a synced revolution.
    sync_up();
    run_to_tooth(20);
    edge_cyc(0, 1, 0);

    // Overflow coinciding with an edge in SEARCH.
    drive(1, 0, 0, 0, 0);
    repeat (3) nat_edge();
    drive(1, 1, 1, 0, 1);

    // Enable dropped while synced.
    sync_up();
    run_to_tooth(40);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 1);

    // Reset while tracking teeth.
    sync_up();
    run_to_tooth(30);
    mid_reset();

    // Random soak with sparse fault injection.
    for (int i = 0; i < 2500; i++) begin
      int r = $urandom_range(0, 999);
      int ph = phase();
      if (r < 3)                 drive(0, 0, 0, 0, 0);
      else if (r < 6)            drive(1, 1'($urandom), 1'($urandom), 0, 1);
      else if (ph == 3)          edge_cyc(r < 300, 0, 0);
      else if (ph >= 4 && r < 9) edge_cyc(m_tooth != TOP, m_tooth != TOP, 0);
      else                       nat_edge();
    end

    // Error counter saturation.
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 1);
    end
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", sb_q.size(), 0);
    chk("err_cnt_sat", err_cnt, ERR_MAX);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
